// File: rtl/pe_mac_dbw.sv
// Weight-stationary systolic PE with ping-pong weight banks; optional saturation via PE_SAT_EN.
// Latency: 1 cycle for activation, weight chain and partial sum.
// No backpressure: every input is consumed on every cycle, every output is registered forward.
module pe_mac_dbw #(
    parameter int  DATA_WIDTH = 8,
    parameter int  SUM_WIDTH  = 2*DATA_WIDTH,
    parameter int  NUM_SLOTS  = 4,
    parameter int  ROW_ID     = 0,
    parameter int  ROW_W      = 4,
    localparam int SLOT_W     = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_valid_in,
    input  logic [ROW_W-1:0]      w_dst_in,
    input  logic [SLOT_W-1:0]     w_slot_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic                  w_valid_out,
    output logic [ROW_W-1:0]      w_dst_out,
    output logic [SLOT_W-1:0]     w_slot_out,
    output logic [DATA_WIDTH-1:0] w_out,
    input  logic                  w_swap,
    input  logic                  signed_mode,
    input  logic                  os_mode,
    input  logic                  acc_clr,
    input  logic                  act_valid_in,
    input  logic [SLOT_W-1:0]     act_slot,
    input  logic [DATA_WIDTH-1:0] act_in,
    output logic                  act_valid_out,
    output logic [DATA_WIDTH-1:0] act_out,
    input  logic [SUM_WIDTH-1:0]  sum_in,
    output logic                  sum_valid_out,
    output logic [SUM_WIDTH-1:0]  sum_out,
    output logic                  ovf
);
    localparam int PW = 2*DATA_WIDTH;

    logic [DATA_WIDTH-1:0] bank [2][NUM_SLOTS];
    logic                  bank_sel;

    logic [DATA_WIDTH-1:0] w_act;
    logic [PW-1:0]         a_ext;
    logic [PW-1:0]         w_ext;
    logic [PW-1:0]         prod;
    logic [SUM_WIDTH-1:0]  p_ext;
    logic [SUM_WIDTH-1:0]  base;
    logic [SUM_WIDTH-1:0]  mac_sum;
    logic                  clamp;

    // Operands are extended to full product width first, so the low PW bits of an
    // unsigned multiply are correct for both signed and unsigned interpretation.
    always_comb begin
        w_act = bank[bank_sel][act_slot];
        a_ext = signed_mode ? PW'($signed(act_in)) : PW'(act_in);
        w_ext = signed_mode ? PW'($signed(w_act))  : PW'(w_act);
        prod  = a_ext * w_ext;
        p_ext = signed_mode ? SUM_WIDTH'($signed(prod)) : SUM_WIDTH'(prod);
        base  = os_mode ? sum_out : sum_in;
    end

`ifdef PE_SAT_EN
    logic [SUM_WIDTH:0] s_ext;

    always_comb begin
        s_ext   = {signed_mode & base[SUM_WIDTH-1], base}
                + {signed_mode & p_ext[SUM_WIDTH-1], p_ext};
        clamp   = 1'b0;
        mac_sum = s_ext[SUM_WIDTH-1:0];
        if (signed_mode) begin
            // Sign of the extra bit tells which rail was crossed.
            if (s_ext[SUM_WIDTH] != s_ext[SUM_WIDTH-1]) begin
                clamp   = 1'b1;
                mac_sum = s_ext[SUM_WIDTH] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                           : {1'b0, {(SUM_WIDTH-1){1'b1}}};
            end
        end else if (s_ext[SUM_WIDTH]) begin
            clamp   = 1'b1;
            mac_sum = {SUM_WIDTH{1'b1}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (act_valid_in && !acc_clr && clamp)
            ovf <= 1'b1;
    end
`else
    always_comb begin
        clamp   = 1'b0;
        mac_sum = base + p_ext;
    end

    assign ovf = clamp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid_out   <= 1'b0;
            w_dst_out     <= '0;
            w_slot_out    <= '0;
            w_out         <= '0;
            act_valid_out <= 1'b0;
            act_out       <= '0;
            sum_valid_out <= 1'b0;
            sum_out       <= '0;
            bank_sel      <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < NUM_SLOTS; s++)
                    bank[b][s] <= '0;
        end else begin
            w_valid_out   <= w_valid_in;
            w_dst_out     <= w_dst_in;
            w_slot_out    <= w_slot_in;
            w_out         <= w_in;
            act_valid_out <= act_valid_in;
            act_out       <= act_in;

            // Pre-swap bank_sel: a write alongside a swap lands in the bank going active.
            if (w_valid_in && w_dst_in == ROW_W'(ROW_ID))
                bank[~bank_sel][w_slot_in] <= w_in;
            if (w_swap)
                bank_sel <= ~bank_sel;

            if (acc_clr) begin
                sum_out       <= '0;
                sum_valid_out <= 1'b0;
            end else if (act_valid_in) begin
                sum_out       <= mac_sum;
                sum_valid_out <= 1'b1;
            end else begin
                sum_valid_out <= 1'b0;
            end
        end
    end
endmodule
